// File: rtl/positcheck.sv
// -----------------------------------------------------------------------------
// positcheck -- result checker for a posit arithmetic unit.
//
// Expected results are queued in operand-issue order into a small FIFO.
// Every DUT result pops the head and compares it against the result as
// unsigned N-bit patterns. Statistics are kept in saturating counters.
// The absolute difference is tracked as the last value and as the
// running maximum.
//
// Optional feature: define POSITCHECK_FLAGS_EN to also check the DUT
// exception flags (res_inf / res_zero) against the expected word.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 run-enable level (rise = start run, fall = drain)
//   clear                 synchronous clear of FIFO and statistics, back to IDLE
//   exp_valid/exp_data    expected-word push, exp_ready = FIFO not full
//   res_valid/res_data    DUT result strobe and word
//   res_inf/res_zero      DUT exception flags
//   match_count/err_count saturating compare totals
//   max_diff/last_diff    largest and most recent absolute difference
//   mismatch              one-cycle pulse per failed compare
//   underflow             sticky: a result arrived with nothing to compare
//   busy/done             high in RUN/DRAIN, high in DONE
// -----------------------------------------------------------------------------
module positcheck #(
    parameter int N     = 32,
    parameter int DEPTH = 16,
    parameter int TOL   = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         clear,
    input  logic         exp_valid,
    input  logic [N-1:0] exp_data,
    output logic         exp_ready,
    input  logic         res_valid,
    input  logic [N-1:0] res_data,
    input  logic         res_inf,
    input  logic         res_zero,
    output logic [31:0]  match_count,
    output logic [31:0]  err_count,
    output logic [N-1:0] max_diff,
    output logic [N-1:0] last_diff,
    output logic         mismatch,
    output logic         underflow,
    output logic         busy,
    output logic         done
);

    localparam int           AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]  DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [N-1:0] TOL_V   = N'(TOL);
    localparam logic [31:0]  CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // |a - b| on unsigned patterns; the larger operand is always the minuend
    // so the result fits in N bits.
    function automatic logic [N-1:0] abs_diff(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = b - a;
        end
        return r;
    endfunction

`ifdef POSITCHECK_FLAGS_EN
    // Expected flags follow from the expected word: NaR pattern -> inf, 0 -> zero.
    function automatic logic flags_ok(input logic [N-1:0] e, input logic ri, input logic rz);
        logic [N-1:0] inf_pat;
        inf_pat = {1'b1, {(N-1){1'b0}}};
        return (ri == (e == inf_pat)) && (rz == (e == {N{1'b0}}));
    endfunction
`else
    // Flags are not checked in this build.
    logic flags_unused_s;
    assign flags_unused_s = res_inf ^ res_zero;
`endif

    state_t          state_q, state_d;
    logic            start_q, start_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            full_q, full_d;
    logic [31:0]     match_count_q, match_count_d;
    logic [31:0]     err_count_q, err_count_d;
    logic [N-1:0]    max_diff_q, max_diff_d;
    logic [N-1:0]    last_diff_q, last_diff_d;
    logic            mismatch_q, mismatch_d;
    logic            underflow_q, underflow_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [N-1:0]    mem_q [DEPTH];

    logic            empty_s;
    logic            res_acc_s;
    logic            push_req_s;
    logic            bypass_s;
    logic            pop_s;
    logic            push_s;
    logic            cmp_s;
    logic            underflow_hit_s;
    logic [N-1:0]    cmp_exp_s;
    logic [N-1:0]    cmp_diff_s;
    logic            cmp_ok_s;

    // Handshake decode: which push/pop/compare happens this cycle.
    always_comb begin
        empty_s    = (count_q == {(AW+1){1'b0}});
        res_acc_s  = res_valid & ((state_q == RUN) | (state_q == DRAIN)) & ~clear;
        push_req_s = exp_valid & (state_q == RUN) & ~clear;
        // An empty FIFO with a same-cycle push hands the word straight to the
        // comparator; it is never stored.
        bypass_s   = res_acc_s & empty_s & push_req_s;
        pop_s      = res_acc_s & ~empty_s;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        push_s     = push_req_s & ~bypass_s & (~full_q | pop_s);
        cmp_s      = pop_s | bypass_s;
        underflow_hit_s = res_acc_s & empty_s & ~push_req_s;
        if (bypass_s) begin
            cmp_exp_s = exp_data;
        end else begin
            cmp_exp_s = mem_q[rd_ptr_q];
        end
        cmp_diff_s = abs_diff(cmp_exp_s, res_data);
`ifdef POSITCHECK_FLAGS_EN
        cmp_ok_s   = (cmp_diff_s <= TOL_V) && flags_ok(cmp_exp_s, res_inf, res_zero);
`else
        cmp_ok_s   = (cmp_diff_s <= TOL_V);
`endif
    end

    // Next-state computation for the FSM, FIFO pointers and statistics.
    always_comb begin
        state_d       = state_q;
        start_d       = start;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        match_count_d = match_count_q;
        err_count_d   = err_count_q;
        max_diff_d    = max_diff_q;
        last_diff_d   = last_diff_q;
        mismatch_d    = 1'b0;
        underflow_d   = underflow_q;

        if (clear) begin
            state_d       = IDLE;
            wr_ptr_d      = {AW{1'b0}};
            rd_ptr_d      = {AW{1'b0}};
            count_d       = {(AW+1){1'b0}};
            match_count_d = 32'd0;
            err_count_d   = 32'd0;
            max_diff_d    = {N{1'b0}};
            last_diff_d   = {N{1'b0}};
            underflow_d   = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase

            if (cmp_s) begin
                last_diff_d = cmp_diff_s;
                if (cmp_diff_s > max_diff_q) begin
                    max_diff_d = cmp_diff_s;
                end else begin
                    max_diff_d = max_diff_q;
                end
                if (cmp_ok_s) begin
                    if (match_count_q != CNT_MAX) begin
                        match_count_d = match_count_q + 32'd1;
                    end else begin
                        match_count_d = match_count_q;
                    end
                end else begin
                    mismatch_d = 1'b1;
                    if (err_count_q != CNT_MAX) begin
                        err_count_d = err_count_q + 32'd1;
                    end else begin
                        err_count_d = err_count_q;
                    end
                end
            end else begin
                last_diff_d = last_diff_q;
            end

            if (underflow_hit_s) begin
                underflow_d = 1'b1;
            end else begin
                underflow_d = underflow_q;
            end

            case (state_q)
                IDLE: begin
                    if (start & ~start_q) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (~start & start_q) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end
                DRAIN: begin
                    // Compares complete at the accepting edge, so an empty
                    // FIFO means nothing is outstanding.
                    if (empty_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                DONE: begin
                    if (start & ~start_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        full_d = (count_d == DEPTH_V);
        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    // Control and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            wr_ptr_q      <= {AW{1'b0}};
            rd_ptr_q      <= {AW{1'b0}};
            count_q       <= {(AW+1){1'b0}};
            full_q        <= 1'b0;
            match_count_q <= 32'd0;
            err_count_q   <= 32'd0;
            max_diff_q    <= {N{1'b0}};
            last_diff_q   <= {N{1'b0}};
            mismatch_q    <= 1'b0;
            underflow_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            full_q        <= full_d;
            match_count_q <= match_count_d;
            err_count_q   <= err_count_d;
            max_diff_q    <= max_diff_d;
            last_diff_q   <= last_diff_d;
            mismatch_q    <= mismatch_d;
            underflow_q   <= underflow_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= exp_data;
        end
    end

    assign exp_ready   = ~full_q;
    assign match_count = match_count_q;
    assign err_count   = err_count_q;
    assign max_diff    = max_diff_q;
    assign last_diff   = last_diff_q;
    assign mismatch    = mismatch_q;
    assign underflow   = underflow_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_positcheck.sv
// -----------------------------------------------------------------------------
// tb_positcheck -- self-checking bench for positcheck (N=32, DEPTH=16, TOL=0).
// A queue-based reference model tracks the expected statistics; every step
// compares all outputs, and directed scenarios add explicit value checks.
// Honours POSITCHECK_FLAGS_EN in its model the same way the design does.
// -----------------------------------------------------------------------------
module tb_positcheck;
    localparam int N     = 32;
    localparam int DEPTH = 16;
    localparam int TOL   = 0;

    logic         clk = 1'b0;
    logic         rst_n, start, clear, exp_valid, res_valid, res_inf, res_zero;
    logic [N-1:0] exp_data, res_data;
    logic         exp_ready, mismatch, underflow, busy, done;
    logic [31:0]  match_count, err_count;
    logic [N-1:0] max_diff, last_diff;

    positcheck #(.N(N), .DEPTH(DEPTH), .TOL(TOL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
        .res_valid(res_valid), .res_data(res_data),
        .res_inf(res_inf), .res_zero(res_zero),
        .match_count(match_count), .err_count(err_count),
        .max_diff(max_diff), .last_diff(last_diff),
        .mismatch(mismatch), .underflow(underflow), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 run, 2 drain, 3 done.
    logic [N-1:0] mq[$];
    int           m_mode;
    logic         m_pstart;
    logic [31:0]  m_match, m_err;
    logic [N-1:0] m_max, m_last;
    logic         m_mis, m_under;
    logic [N-1:0] inf_pat;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_mode = 0; m_pstart = 1'b0;
        m_match = 32'd0; m_err = 32'd0;
        m_max = '0; m_last = '0;
        m_mis = 1'b0; m_under = 1'b0;
    endtask

    task automatic m_compare(input logic [N-1:0] e, input logic [N-1:0] r);
        logic [N-1:0] d;
        bit ok;
        d  = (e > r) ? (e - r) : (r - e);
        ok = (d <= TOL);
`ifdef POSITCHECK_FLAGS_EN
        ok = ok && (res_inf == (e == inf_pat)) && (res_zero == (e == '0));
`endif
        if (ok) begin
            if (m_match != 32'hFFFF_FFFF) m_match = m_match + 32'd1;
        end else begin
            if (m_err != 32'hFFFF_FFFF) m_err = m_err + 32'd1;
            m_mis = 1'b1;
        end
        m_last = d;
        if (d > m_max) m_max = d;
    endtask

    // Apply the current inputs to the model, then clock the DUT and compare.
    task automatic m_update();
        int sz;
        bit rise, fall, racc, preq, pacc;
        logic [N-1:0] e;
        m_mis = 1'b0;
        if (clear) begin
            mq.delete();
            m_mode = 0; m_match = 32'd0; m_err = 32'd0;
            m_max = '0; m_last = '0; m_under = 1'b0;
        end else begin
            sz   = mq.size();
            rise = start && !m_pstart;
            fall = !start && m_pstart;
            racc = res_valid && (m_mode == 1 || m_mode == 2);
            preq = (m_mode == 1) && exp_valid;
            pacc = preq && (sz < DEPTH || (racc && sz > 0));
            if (racc) begin
                if (sz > 0) begin
                    e = mq.pop_front();
                    m_compare(e, res_data);
                end else if (preq) begin
                    m_compare(exp_data, res_data);
                    pacc = 1'b0;
                end else begin
                    m_under = 1'b1;
                end
            end
            if (pacc) mq.push_back(exp_data);
            case (m_mode)
                0: if (rise) m_mode = 1;
                1: if (fall) m_mode = 2;
                2: if (sz == 0) m_mode = 3;
                3: if (rise) m_mode = 0;
                default: m_mode = 0;
            endcase
        end
        m_pstart = start;
    endtask

    task automatic check_all();
        chk("exp_ready",   64'(exp_ready),   64'(mq.size() < DEPTH));
        chk("match_count", 64'(match_count), 64'(m_match));
        chk("err_count",   64'(err_count),   64'(m_err));
        chk("max_diff",    64'(max_diff),    64'(m_max));
        chk("last_diff",   64'(last_diff),   64'(m_last));
        chk("mismatch",    64'(mismatch),    64'(m_mis));
        chk("underflow",   64'(underflow),   64'(m_under));
        chk("busy",        64'(busy),        64'(m_mode == 1 || m_mode == 2));
        chk("done",        64'(done),        64'(m_mode == 3));
    endtask

    task automatic step();
        m_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic quiet();
        exp_valid = 1'b0; res_valid = 1'b0; clear = 1'b0;
        res_inf = 1'b0; res_zero = 1'b0;
    endtask

    initial begin
        logic [31:0] saved_m, saved_e;
        int guard;
        inf_pat = '0;
        inf_pat[N-1] = 1'b1;
        rst_n = 1'b0; start = 1'b0; clear = 1'b0;
        exp_valid = 1'b0; exp_data = '0; res_valid = 1'b0; res_data = '0;
        res_inf = 1'b0; res_zero = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("reset_ready", 64'(exp_ready), 64'd1);
        rst_n = 1'b1;
        step();

        // Basic match then off-by-two mismatch
        start = 1'b1; step();
        exp_valid = 1'b1; exp_data = 32'h4000_0000; step();
        exp_data = 32'h4800_0000; step();
        exp_valid = 1'b0;
        res_valid = 1'b1; res_data = 32'h4000_0000; step();
        res_data = 32'h4800_0002; step();
        res_valid = 1'b0;
        chk("basic_match",  64'(match_count), 64'd1);
        chk("basic_err",    64'(err_count),   64'd1);
        chk("basic_last",   64'(last_diff),   64'd2);
        chk("basic_max",    64'(max_diff),    64'd2);
        chk("basic_pulse",  64'(mismatch),    64'd1);
        step();
        chk("basic_pulse_end", 64'(mismatch), 64'd0);

        // Fill the FIFO, then push and pop together while full
        exp_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_data = 32'h1000 + 32'(i); step();
        end
        chk("full_ready", 64'(exp_ready), 64'd0);
        saved_m = match_count;
        res_valid = 1'b1; res_data = 32'h1000; exp_data = 32'h2000; step();
        chk("full_both_ready", 64'(exp_ready), 64'd0);
        chk("full_both_match", 64'(match_count), 64'(saved_m + 32'd1));
        exp_valid = 1'b0;
        guard = 0;
        while (mq.size() > 0 && guard < 40) begin
            res_data = mq[0]; step(); guard++;
        end
        chk("drain_guard", 64'(guard < 40), 64'd1);
        res_valid = 1'b0;
        step();

        // Underflow, then bypass compare
        saved_m = match_count; saved_e = err_count;
        res_valid = 1'b1; res_data = 32'h7; step();
        res_valid = 1'b0;
        chk("uflow_flag",  64'(underflow),   64'd1);
        chk("uflow_match", 64'(match_count), 64'(saved_m));
        chk("uflow_err",   64'(err_count),   64'(saved_e));
        step();
        exp_valid = 1'b1; exp_data = 32'h3; res_valid = 1'b1; res_data = 32'h3; step();
        quiet();
        chk("bypass_match", 64'(match_count), 64'(saved_m + 32'd1));

        // Drain with 3 queued entries, then clear
        exp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_data = 32'h5000 + 32'(i); step();
        end
        exp_valid = 1'b0; start = 1'b0; step();
        chk("drain_busy", 64'(busy), 64'd1);
        res_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            res_data = 32'h5000 + 32'(i); step();
            chk("drain_busy_cmp", 64'(busy), 64'd1);
        end
        res_valid = 1'b0; step();
        chk("drain_done", 64'(done), 64'd1);
        chk("drain_idle", 64'(busy), 64'd0);
        clear = 1'b1; step(); clear = 1'b0;
        chk("clear_match", 64'(match_count), 64'd0);
        chk("clear_err",   64'(err_count),   64'd0);
        chk("clear_done",  64'(done),        64'd0);

        // NaR pattern with inf flag low
        start = 1'b1; step();
        exp_valid = 1'b1; exp_data = 32'h8000_0000; step();
        exp_valid = 1'b0;
        res_valid = 1'b1; res_data = 32'h8000_0000; res_inf = 1'b0; step();
        res_valid = 1'b0;
`ifdef POSITCHECK_FLAGS_EN
        chk("nar_flag_err", 64'(err_count), 64'd1);
`else
        chk("nar_flag_match", 64'(match_count), 64'd1);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) start = ~start;
            clear     = ($urandom_range(0, 99) == 0);
            exp_valid = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0: exp_data = '0;
                1: exp_data = inf_pat;
                default: exp_data = $urandom;
            endcase
            res_valid = $urandom_range(0, 2) != 0;
            if (mq.size() > 0) res_data = mq[0] + 32'($urandom_range(0, 1) * $urandom_range(0, 9));
            else res_data = exp_data + 32'($urandom_range(0, 1));
            res_inf  = (res_data == inf_pat) ^ ($urandom_range(0, 7) == 0);
            res_zero = (res_data == '0) ^ ($urandom_range(0, 7) == 0);
            step();
        end
        quiet();

        // Reset right after an accepted result
        clear = 1'b1; step(); clear = 1'b0;
        start = 1'b0; step();
        start = 1'b1; step();
        exp_valid = 1'b1; exp_data = 32'h5; step(); exp_valid = 1'b0;
        res_valid = 1'b1; res_data = 32'h5; step(); res_valid = 1'b0;
        #2 rst_n = 1'b0;
        start = 1'b0;
        #1;
        m_reset();
        check_all();
        chk("rst_match", 64'(match_count), 64'd0);
        chk("rst_ready", 64'(exp_ready),   64'd1);
        @(posedge clk); #1;
        check_all();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
